// File: rtl/rtc_bus_engine.sv
// rtl/rtc_bus_engine.sv - RTC multiplexed address/data bus engine for read/write bursts
module rtc_bus_engine #(
    parameter int DATA_W    = 8,
    parameter int T_PHASE   = 4,
    parameter int BURST_MAX = 16,
    parameter int LEN_W     = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              rw,
    input  logic              inc,
    input  logic [DATA_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wdata,
    output logic              wd_take,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic [LEN_W-1:0]  rd_idx,
    output logic              busy,
    output logic              done,
    output logic              AD,
    output logic              CS,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in
);
    localparam int PH_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_GAP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                rw_q, rw_d, inc_q, inc_d;
    logic [DATA_W-1:0]   cur_addr_q, cur_addr_d, wbyte_q, wbyte_d;
    logic [LEN_W-1:0]    len_q, len_d, idx_q, idx_d;
    logic                ad_q, ad_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic                oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic                take_q, take_d, rv_q, rv_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d, rdata_q, rdata_d;
    logic [LEN_W-1:0]    rd_idx_q, rd_idx_d;
    logic                phase_done, last_byte, enter_d_set;

    assign phase_done  = (phase_q == PH_W'(T_PHASE - 1));
    assign last_byte   = (idx_q == len_q - 1'b1);
    assign enter_d_set = (state_d == S_D_SET) && (state_q != S_D_SET);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            rw_q       <= 1'b0;
            inc_q      <= 1'b0;
            cur_addr_q <= '0;
            wbyte_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            ad_q       <= 1'b1;
            cs_q       <= 1'b1;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            take_q     <= 1'b0;
            rv_q       <= 1'b0;
            bus_out_q  <= '0;
            rdata_q    <= '0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            inc_q      <= inc_d;
            cur_addr_q <= cur_addr_d;
            wbyte_q    <= wbyte_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            ad_q       <= ad_d;
            cs_q       <= cs_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            take_q     <= take_d;
            rv_q       <= rv_d;
            bus_out_q  <= bus_out_d;
            rdata_q    <= rdata_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_A_SET;
            S_A_SET: if (phase_done) state_d = S_A_STB;
            S_A_STB: if (phase_done) state_d = S_A_HLD;
            S_A_HLD: if (phase_done) state_d = S_D_SET;
            S_D_SET: if (phase_done) state_d = S_D_STB;
            S_D_STB: if (phase_done) state_d = S_D_HLD;
            S_D_HLD: if (phase_done) state_d = last_byte ? S_DONE : S_GAP;
            S_GAP:   if (phase_done) state_d = S_A_SET;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst context: captured on acceptance, advanced when leaving D_HLD for GAP.
    always_comb begin
        phase_d    = (state_d != state_q || state_q == S_IDLE) ? '0 : phase_q + 1'b1;
        rw_d       = rw_q;
        inc_d      = inc_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        wbyte_d    = wbyte_q;
        if (state_q == S_IDLE && start) begin
            rw_d       = rw;
            inc_d      = inc;
            cur_addr_d = addr;
            idx_d      = '0;
            if (len == '0)
                len_d = LEN_W'(1);
            else if (len > LEN_W'(BURST_MAX))
                len_d = LEN_W'(BURST_MAX);
            else
                len_d = len;
        end
        if (state_q == S_D_HLD && state_d == S_GAP) begin
            idx_d      = idx_q + 1'b1;
            cur_addr_d = cur_addr_q + DATA_W'(inc_q);
        end
        if (enter_d_set && !rw_q)
            wbyte_d = wdata;
    end

    // Output values are decoded from the next state so they line up with the registered state.
    always_comb begin
        ad_d      = 1'b1;
        cs_d      = 1'b1;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        oe_d      = 1'b0;
        bus_out_d = '0;
        case (state_d)
            S_A_SET, S_A_STB, S_A_HLD: begin
                cs_d      = 1'b0;
                ad_d      = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = cur_addr_d;
                wr_d      = (state_d != S_A_STB);
            end
            S_D_SET, S_D_STB, S_D_HLD: begin
                cs_d = 1'b0;
                if (!rw_q) begin
                    oe_d      = 1'b1;
                    bus_out_d = wbyte_d;
                    wr_d      = (state_d != S_D_STB);
                end else begin
                    rd_d      = (state_d != S_D_STB);
                end
            end
            default: ;
        endcase
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        take_d   = enter_d_set && !rw_q;
        rv_d     = rw_q && (state_d == S_D_HLD) && (state_q == S_D_STB);
        rdata_d  = rv_d ? bus_in : rdata_q;
        rd_idx_d = rv_d ? idx_q : rd_idx_q;
    end

    assign AD       = ad_q;
    assign CS       = cs_q;
    assign RD       = rd_q;
    assign WR       = wr_q;
    assign bus_oe   = oe_q;
    assign bus_out  = bus_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wd_take  = take_q;
    assign rd_valid = rv_q;
    assign rdata    = rdata_q;
    assign rd_idx   = rd_idx_q;
endmodule

// File: tb/tb_rtc_bus_engine.sv
// tb/tb_rtc_bus_engine.sv - directed self-checking bench for rtc_bus_engine
module tb_rtc_bus_engine;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0, rw = 1'b0, inc = 1'b0;
    logic [7:0] addr = '0, wdata = '0, bus_in;
    logic [4:0] len = '0;
    logic       wd_take, rd_valid, busy, done, AD, CS, RD, WR, bus_oe;
    logic [7:0] rdata, bus_out, lat_addr = '0;
    logic [4:0] rd_idx;

    int checks = 0, failures = 0;

    rtc_bus_engine #(.DATA_W(8), .T_PHASE(2), .BURST_MAX(16), .LEN_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .rw(rw), .inc(inc), .addr(addr),
        .len(len), .wdata(wdata), .wd_take(wd_take), .rdata(rdata), .rd_valid(rd_valid),
        .rd_idx(rd_idx), .busy(busy), .done(done), .AD(AD), .CS(CS), .RD(RD), .WR(WR),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    always #5 Clk = ~Clk;

    // RTC model: latches the address on the WR strobe, returns address+0x10 while RD is low.
    always @(posedge Clk) if (!WR && !AD) lat_addr <= bus_out;
    assign bus_in = RD ? 8'h00 : lat_addr + 8'h10;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    logic [63:0] cs_m, wr_m, take_m, done_m, busy_m, rv_m;
    int          done_cyc, done_cnt, take_cnt, viol;
    logic [7:0]  aq[$], dq[$], rq[$];
    logic [4:0]  iq[$];

    function automatic logic [7:0] qg(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    // Starts a burst at the current negedge (cycle 0) and records ncyc following cycles.
    task automatic run_burst(input logic r, input logic in_c, input logic [7:0] a,
                             input logic [4:0] l, input logic [7:0] wd, input int ncyc,
                             input int glitch_cyc);
        logic prev_wr = 1'b1;
        cs_m = '0; wr_m = '0; take_m = '0; done_m = '0; busy_m = '0; rv_m = '0;
        done_cyc = -1; done_cnt = 0; take_cnt = 0; viol = 0;
        aq.delete(); dq.delete(); rq.delete(); iq.delete();
        rw = r; inc = in_c; addr = a; len = l; wdata = wd; start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge Clk);
            start = 1'b0;
            if (c == glitch_cyc) begin
                start = 1'b1; rw = ~r; addr = 8'h80; len = 5'd4;
            end
            if (c < 64) begin
                cs_m[c] = !CS; wr_m[c] = !WR; take_m[c] = wd_take;
                done_m[c] = done; busy_m[c] = busy; rv_m[c] = rd_valid;
            end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (wd_take) take_cnt++;
            if (rd_valid) begin rq.push_back(rdata); iq.push_back(rd_idx); end
            if (!WR && prev_wr && !AD) aq.push_back(bus_out);
            if (!WR && prev_wr && AD) dq.push_back(bus_out);
            if ((bus_oe && !RD) || (!RD && !WR)) viol++;
            prev_wr = WR;
        end
        start = 1'b0;
    endtask

    initial begin
        int idle_bad;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_strobes", {AD, CS, RD, WR}, 4'hF);
        chk("rst_oe_busy", {bus_oe, busy, done, wd_take, rd_valid}, 5'b0);
        chk("rst_data", {bus_out, rdata, rd_idx}, 21'h0);
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if ({AD, CS, RD, WR, bus_oe, busy} !== 6'b111100) idle_bad++;
        end
        chk("idle_20", idle_bad, 0);

        run_burst(1'b0, 1'b0, 8'h21, 5'd1, 8'h45, 16, 0);
        chk("wr_cs", cs_m, rng(1, 12));
        chk("wr_wr", wr_m, rng(3, 4) | rng(9, 10));
        chk("wr_take", take_m, 64'h80);
        chk("wr_done", done_m, 64'h2000);
        chk("wr_busy", busy_m, rng(1, 13));
        chk("wr_addr", {aq.size(), qg(aq, 0)}, {32'd1, 8'h21});
        chk("wr_data", {dq.size(), qg(dq, 0)}, {32'd1, 8'h45});
        chk("wr_viol", viol, 0);

        run_burst(1'b1, 1'b1, 8'h22, 5'd3, 8'h00, 44, 0);
        chk("rd_rdata", {rq.size(), qg(rq, 0), qg(rq, 1), qg(rq, 2)}, {32'd3, 24'h323334});
        chk("rd_idx", {iq.size(), 3'b0, iq.size() > 0 ? iq[0] : 5'h1f,
                       iq.size() > 1 ? iq[1] : 5'h1f, iq.size() > 2 ? iq[2] : 5'h1f},
            {32'd3, 3'b0, 5'd0, 5'd1, 5'd2});
        chk("rd_valid_cyc", rv_m, (64'h1 << 11) | (64'h1 << 25) | (64'h1 << 39));
        chk("rd_cs_gaps", cs_m, rng(1, 12) | rng(15, 26) | rng(29, 40));
        chk("rd_done", {done_cyc, done_cnt}, {32'd41, 32'd1});
        chk("rd_no_wr_data", {dq.size(), take_cnt, viol}, 96'h0);

        run_burst(1'b1, 1'b0, 8'hFF, 5'd2, 8'h00, 30, 0);
        chk("noinc_addr", {aq.size(), qg(aq, 0), qg(aq, 1)}, {32'd2, 16'hFFFF});
        run_burst(1'b1, 1'b1, 8'hFF, 5'd2, 8'h00, 30, 0);
        chk("wrap_addr", {aq.size(), qg(aq, 0), qg(aq, 1)}, {32'd2, 16'hFF00});
        chk("wrap_rdata", {qg(rq, 0), qg(rq, 1)}, 16'h0F10);

        run_burst(1'b0, 1'b0, 8'h10, 5'd0, 8'hA5, 20, 0);
        chk("len0_done", {done_cyc, done_cnt, take_cnt}, {32'd13, 32'd1, 32'd1});

        run_burst(1'b0, 1'b1, 8'h00, 5'd31, 8'h3C, 240, 0);
        chk("len31_done", {done_cyc, done_cnt}, {32'd223, 32'd1});
        chk("len31_bytes", {aq.size(), take_cnt, qg(aq, 15)}, {32'd16, 32'd16, 8'h0F});

        run_burst(1'b0, 1'b0, 8'h44, 5'd2, 8'h99, 40, 5);
        chk("busy_start_done", {done_cyc, done_cnt}, {32'd27, 32'd1});
        chk("busy_start_addr", {aq.size(), qg(aq, 0), qg(aq, 1)}, {32'd2, 16'h4444});
        chk("busy_start_after", busy_m[63:28], 36'h0);

        // Abort a write while its data strobe is active.
        run_burst(1'b0, 1'b0, 8'h55, 5'd1, 8'h66, 9, 0);
        chk("abort_pre_wr", WR, 1'b0);
        Reset = 1'b1;
        #1;
        chk("abort_now", {WR, CS, bus_oe, busy, AD, RD}, 6'b110011);
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (done) done_cnt++;
        end
        Reset = 1'b0;
        chk("abort_no_done", done_cnt, 0);
        run_burst(1'b0, 1'b0, 8'h33, 5'd1, 8'h5A, 16, 0);
        chk("post_abort_wr", wr_m, rng(3, 4) | rng(9, 10));
        chk("post_abort_ad", {qg(aq, 0), qg(dq, 0), done_cyc[7:0]}, {8'h33, 8'h5A, 8'd13});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
